// File: rtl/reduce_merge_router.sv
// Router-side reduce/merge: one flit from every masked input port is combined per
// cycle (sum or signed max) and sent out on the single OUTPUT_SEL port.
module reduce_merge_router #(
    parameter int                NPORT      = 5,
    parameter int                DW         = 34,
    parameter int                DEPTH_LOG  = 2,
    parameter logic [0:NPORT-1]  INPUT_MASK = '0,
    parameter logic [0:NPORT-1]  OUTPUT_SEL = '0,
    parameter int                MODE       = 0,
    parameter int                SAT        = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] data_i  [NPORT],
    input  logic          valid_i [NPORT],
    output logic          ready_o [NPORT],
    output logic [DW-1:0] data_o  [NPORT],
    output logic          valid_o [NPORT],
    input  logic          ready_i [NPORT],
    output logic          err_o,
    output logic [15:0]   pkt_cnt_o
);
    localparam int PW = DW - 2;
    localparam int SW = PW + $clog2(NPORT);

    localparam logic [1:0] T_HEAD = 2'b00;
    localparam logic [1:0] T_BODY = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;
    localparam logic [1:0] T_RSVD = 2'b11;

    localparam logic [0:0] S_HEAD = 1'b0;
    localparam logic [0:0] S_BODY = 1'b1;

    localparam logic signed [PW-1:0]    P_MAX    = {1'b0, {(PW-1){1'b1}}};
    localparam logic signed [PW-1:0]    P_MIN    = {1'b1, {(PW-1){1'b0}}};
    localparam logic [DEPTH_LOG:0]      FULL_CNT = {1'b1, {DEPTH_LOG{1'b0}}};

    // Handshake: a flit moves on any rising edge where valid and ready are both high;
    // valid must not depend on ready, and a held flit stays stable until taken.
    logic [NPORT-1:0] avail_w;
    logic [DW-1:0]    head_w [NPORT];
    logic             all_w, ready_sel_w, fire_w;

    logic [0:0]       state_q, state_d;
    logic [DW-1:0]    data_q, data_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [15:0]      pkt_q, pkt_d;

    for (genvar p = 0; p < NPORT; p++) begin : g_port
        if (INPUT_MASK[p]) begin : g_fifo
            logic [DW-1:0]        mem_q [2**DEPTH_LOG];
            logic [DEPTH_LOG-1:0] rd_q, wr_q;
            logic [DEPTH_LOG:0]   cnt_q;
            logic                 full_w, push_w;

            // Full refuses writes even when a pop happens in the same cycle.
            assign full_w     = (cnt_q == FULL_CNT);
            assign push_w     = valid_i[p] & ~full_w;
            assign ready_o[p] = ~full_w;
            assign avail_w[p] = (cnt_q != '0);
            assign head_w[p]  = mem_q[rd_q];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_q  <= '0;
                    wr_q  <= '0;
                    cnt_q <= '0;
                end else begin
                    if (push_w) wr_q <= wr_q + 1'b1;
                    if (fire_w) rd_q <= rd_q + 1'b1;
                    cnt_q <= cnt_q + {{DEPTH_LOG{1'b0}}, push_w} - {{DEPTH_LOG{1'b0}}, fire_w};
                end
            end

            always_ff @(posedge clk) begin
                if (push_w) mem_q[wr_q] <= data_i[p];
            end
        end else begin : g_none
            assign ready_o[p] = 1'b0;
            assign avail_w[p] = 1'b0;
            assign head_w[p]  = '0;
        end

        assign data_o[p]  = OUTPUT_SEL[p] ? data_q : '0;
        assign valid_o[p] = OUTPUT_SEL[p] & valid_q;
    end

    always_comb begin
        all_w       = |INPUT_MASK;
        ready_sel_w = 1'b0;
        for (int p = 0; p < NPORT; p++) begin
            if (INPUT_MASK[p] && !avail_w[p]) all_w = 1'b0;
            if (OUTPUT_SEL[p]) ready_sel_w = ready_sel_w | ready_i[p];
        end
    end

    assign fire_w = all_w & (~valid_q | ready_sel_w);

    logic                 lead_found, mismatch, rsvd_seen, head_seen;
    logic [DW-1:0]        lead_flit;
    logic [1:0]           lead_type, raw_t, eff_t;
    logic signed [PW-1:0] pay_v, max_v, red_v;
    logic signed [SW-1:0] sum_v;

    // The lowest-index masked port leads: it decides the output type and the HEAD flit.
    always_comb begin
        lead_found = 1'b0;
        mismatch   = 1'b0;
        rsvd_seen  = 1'b0;
        head_seen  = 1'b0;
        lead_flit  = '0;
        lead_type  = T_BODY;
        raw_t      = T_BODY;
        eff_t      = T_BODY;
        pay_v      = '0;
        max_v      = '0;
        sum_v      = '0;
        for (int p = 0; p < NPORT; p++) begin
            if (INPUT_MASK[p]) begin
                raw_t     = head_w[p][DW-1:DW-2];
                eff_t     = (raw_t == T_RSVD) ? T_BODY : raw_t;
                pay_v     = head_w[p][PW-1:0];
                rsvd_seen = rsvd_seen | (raw_t == T_RSVD);
                head_seen = head_seen | (eff_t == T_HEAD);
                if (!lead_found) begin
                    lead_found = 1'b1;
                    lead_flit  = head_w[p];
                    lead_type  = eff_t;
                    max_v      = pay_v;
                end else begin
                    if (eff_t != lead_type) mismatch = 1'b1;
                    if (pay_v > max_v) max_v = pay_v;
                end
                sum_v = sum_v + SW'(pay_v);
            end
        end

        if (MODE == 1)                            red_v = max_v;
        else if ((SAT != 0) && (sum_v > SW'(P_MAX))) red_v = P_MAX;
        else if ((SAT != 0) && (sum_v < SW'(P_MIN))) red_v = P_MIN;
        else                                      red_v = sum_v[PW-1:0];
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        err_d   = err_q;
        pkt_d   = pkt_q;
        if (ready_sel_w) valid_d = 1'b0;
        if (fire_w) begin
            if (mismatch || rsvd_seen) err_d = 1'b1;
            if (state_q == S_HEAD) begin
                if (lead_type == T_HEAD) begin
                    data_d  = lead_flit;
                    valid_d = 1'b1;
                    state_d = S_BODY;
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                if (head_seen) err_d = 1'b1;
                data_d  = {lead_type, red_v};
                valid_d = 1'b1;
                if (lead_type == T_TAIL) begin
                    state_d = S_HEAD;
                    pkt_d   = pkt_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_HEAD;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            pkt_q   <= pkt_d;
        end
    end

    assign err_o     = err_q;
    assign pkt_cnt_o = pkt_q;
endmodule

// File: tb/tb_reduce_merge_router.sv
// Directed bench for reduce_merge_router: sum/saturation, wrap, max, backpressure,
// protocol error and mid-packet reset, across four parameterisations.
module tb_reduce_merge_router;
    localparam logic [1:0] H = 2'b00;
    localparam logic [1:0] B = 2'b01;
    localparam logic [1:0] T = 2'b10;

    logic clk = 1'b0;
    logic rst;

    logic [33:0] d [5];
    logic        v [5];
    logic [33:0] dc [5];
    logic        vc [5];
    logic        rdy [5];

    logic        ra [5], va [5], rb [5], vb [5], rc [5], vcc [5], rz [5], vz [5];
    logic [33:0] da [5], db [5], dcc [5], dz [5];
    logic        erra, errb, errc, errz;
    logic [15:0] pkta, pktb, pktc, pktz;

    int checks   = 0;
    int failures = 0;
    int p_next;
    logic ready_seen;

    always #5 clk = ~clk;

    reduce_merge_router #(.INPUT_MASK(5'b01100), .OUTPUT_SEL(5'b10000), .MODE(0), .SAT(1)) dut_a (
        .clk(clk), .rst(rst), .data_i(d), .valid_i(v), .ready_o(ra),
        .data_o(da), .valid_o(va), .ready_i(rdy), .err_o(erra), .pkt_cnt_o(pkta));

    reduce_merge_router #(.INPUT_MASK(5'b01100), .OUTPUT_SEL(5'b10000), .MODE(0), .SAT(0)) dut_b (
        .clk(clk), .rst(rst), .data_i(d), .valid_i(v), .ready_o(rb),
        .data_o(db), .valid_o(vb), .ready_i(rdy), .err_o(errb), .pkt_cnt_o(pktb));

    reduce_merge_router #(.INPUT_MASK(5'b11100), .OUTPUT_SEL(5'b00010), .MODE(1), .SAT(1)) dut_c (
        .clk(clk), .rst(rst), .data_i(dc), .valid_i(vc), .ready_o(rc),
        .data_o(dcc), .valid_o(vcc), .ready_i(rdy), .err_o(errc), .pkt_cnt_o(pktc));

    reduce_merge_router #(.INPUT_MASK(5'b00000), .OUTPUT_SEL(5'b10000), .MODE(0), .SAT(1)) dut_z (
        .clk(clk), .rst(rst), .data_i(d), .valid_i(v), .ready_o(rz),
        .data_o(dz), .valid_o(vz), .ready_i(rdy), .err_o(errz), .pkt_cnt_o(pktz));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drv2(input logic [1:0] t1, input logic [31:0] p1,
                        input logic [1:0] t2, input logic [31:0] p2);
        d[1] = {t1, p1};
        d[2] = {t2, p2};
        v[1] = 1'b1;
        v[2] = 1'b1;
    endtask

    task automatic drvc(input logic [1:0] t, input logic [31:0] p0,
                        input logic [31:0] p1, input logic [31:0] p2);
        dc[0] = {t, p0};
        dc[1] = {t, p1};
        dc[2] = {t, p2};
        vc[0] = 1'b1;
        vc[1] = 1'b1;
        vc[2] = 1'b1;
    endtask

    task automatic idle();
        for (int i = 0; i < 5; i++) begin
            v[i]  = 1'b0;
            vc[i] = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d[i] = '0; dc[i] = '0; v[i] = 1'b0; vc[i] = 1'b0; rdy[i] = 1'b1;
        end
        repeat (2) @(negedge clk);
        check("rst_valid", va[0], 1'b0);
        check("rst_data", da[0], 34'h0);
        check("rst_err", erra, 1'b0);
        check("rst_pkt", pkta, 16'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_masked", ra[1], 1'b1);
        check("ready_unmasked", ra[0], 1'b0);

        // basic sum packet
        drv2(H, 32'h11, H, 32'h22); cyc();
        drv2(B, 32'd3, B, 32'd4); cyc();
        check("sum_head", {va[0], da[0]}, {1'b1, H, 32'h11});
        drv2(T, 32'd5, T, 32'hFFFF_FFF9); cyc();
        check("sum_body", {va[0], da[0]}, {1'b1, B, 32'd7});
        check("unsel_port", {va[1], da[1]}, 35'h0);
        idle(); cyc();
        check("sum_tail", {va[0], da[0]}, {1'b1, T, 32'hFFFF_FFFE});
        check("sum_pkt", pkta, 16'd1);
        check("sum_err", erra, 1'b0);
        cyc();
        check("sum_valid_clear", va[0], 1'b0);

        // saturation vs wrap (a/b) alongside signed max (c)
        drv2(H, 32'h1, H, 32'h1); drvc(H, 32'h1, 32'h2, 32'h3); cyc();
        drv2(B, 32'h7FFF_FFFF, B, 32'h1);
        drvc(B, 32'hFFFF_FFFB, 32'h2, 32'hFFFF_FFFF); cyc();
        check("sat_head", {va[0], da[0]}, {1'b1, H, 32'h1});
        check("max_head", {vcc[3], dcc[3]}, {1'b1, H, 32'h1});
        drv2(B, 32'h8000_0000, B, 32'h8000_0000);
        drvc(B, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE); cyc();
        check("sat_pos", {va[0], da[0]}, {1'b1, B, 32'h7FFF_FFFF});
        check("wrap_pos", {vb[0], db[0]}, {1'b1, B, 32'h8000_0000});
        check("max_mixed", {vcc[3], dcc[3]}, {1'b1, B, 32'h2});
        drv2(T, 32'h0, T, 32'h0);
        drvc(T, 32'hFFFF_FFFB, 32'hFFFF_FFFD, 32'hFFFF_FFF7); cyc();
        check("sat_neg", {va[0], da[0]}, {1'b1, B, 32'h8000_0000});
        check("wrap_neg", {vb[0], db[0]}, {1'b1, B, 32'h0});
        check("max_neg", {vcc[3], dcc[3]}, {1'b1, B, 32'hFFFF_FFFF});
        check("max_unsel", vcc[0], 1'b0);
        idle(); cyc();
        check("sat_tail", {va[0], da[0]}, {1'b1, T, 32'h0});
        check("max_tail", {vcc[3], dcc[3]}, {1'b1, T, 32'hFFFF_FFFD});
        check("sat_pkt", pkta, 16'd2);
        check("wrap_pkt", pktb, 16'd2);
        check("max_pkt", pktc, 16'd1);
        check("max_err", errc, 1'b0);
        cyc();

        // backpressure: output held, FIFOs fill to 4, nothing lost
        rdy[0] = 1'b0;
        drv2(H, 32'h33, H, 32'h44); cyc();
        p_next = 1;
        for (int i = 0; i < 10; i++) begin
            drv2(B, p_next, B, p_next);
            ready_seen = ra[1];
            cyc();
            if (ready_seen) p_next++;
            check("bp_hold", {va[0], da[0]}, {1'b1, H, 32'h33});
        end
        idle();
        check("bp_full_ready", {ra[1], ra[2]}, 2'b00);
        check("bp_accepted", p_next - 1, 4);
        rdy[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            check("bp_drain", {va[0], da[0]}, {1'b1, B, 32'(2 * k)});
        end
        check("bp_ready_back", ra[1], 1'b1);
        drv2(T, 32'h0, T, 32'h0); cyc();
        idle(); cyc();
        check("bp_tail", {va[0], da[0]}, {1'b1, T, 32'h0});
        check("bp_pkt", pkta, 16'd3);
        cyc();

        // lowest-index BODY while idle: dropped, sticky error
        drv2(B, 32'h9, H, 32'h9); cyc();
        idle(); cyc();
        check("drop_no_out", va[0], 1'b0);
        check("drop_err", erra, 1'b1);
        check("drop_pkt", pkta, 16'd3);
        drv2(H, 32'h55, H, 32'h55); cyc();
        drv2(B, 32'h1, B, 32'h1); cyc();
        check("post_drop_head", {va[0], da[0]}, {1'b1, H, 32'h55});
        check("err_sticky", erra, 1'b1);
        idle(); cyc();
        check("post_drop_body", {va[0], da[0]}, {1'b1, B, 32'h2});

        // asynchronous reset mid-packet
        #2 rst = 1'b1;
        #1;
        check("arst_valid", va[0], 1'b0);
        check("arst_data", da[0], 34'h0);
        check("arst_err", erra, 1'b0);
        check("arst_pkt", pkta, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        drv2(H, 32'h66, H, 32'h77); cyc();
        drv2(T, 32'h4, T, 32'h5); cyc();
        check("rerun_head", {va[0], da[0]}, {1'b1, H, 32'h66});
        idle(); cyc();
        check("rerun_tail", {va[0], da[0]}, {1'b1, T, 32'h9});
        check("rerun_pkt", pkta, 16'd1);
        check("rerun_err", erra, 1'b0);

        // empty mask never fires
        check("nomask_valid", {vz[0], vz[1], vz[2], vz[3], vz[4]}, 5'b00000);
        check("nomask_ready", {rz[1], rz[2]}, 2'b00);
        check("nomask_pkt", pktz, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reduce_merge_router.md
REDUCE_MERGE_ROUTER -- requirements
Module: reduce_merge_router

Interface
REQ-001 SHALL have parameter NPORT, default 5, number of router ports (index 0 local, 1 west, 2 east, 3 north, 4 south, ...).
REQ-002 SHALL have parameter DW, default 34, flit width: bits [DW-1:DW-2] flit type, bits [DW-3:0] signed payload.
REQ-003 SHALL have parameter DEPTH_LOG, default 2, input FIFO depth 2**DEPTH_LOG.
REQ-004 SHALL have parameter INPUT_MASK [0:NPORT-1], default all 0, 1 = port participates in the merge.
REQ-005 SHALL have parameter OUTPUT_SEL [0:NPORT-1], default 0, one-hot merged output port.
REQ-006 SHALL have parameter MODE, default 0, 0 = sum reduction, 1 = signed max reduction.
REQ-007 SHALL have parameter SAT, default 1, 1 = saturating sum, 0 = wrap-around sum.
REQ-008 clk  input  1  single clock; all state on rising edge.
REQ-009 rst  input  1  reset, asynchronous, active-high.
REQ-010 data_i[NPORT]  input  DW  incoming flits.
REQ-011 valid_i[NPORT]  input  1  incoming flit valid.
REQ-012 ready_o[NPORT]  output  1  input accept.
REQ-013 data_o[NPORT]  output  DW  outgoing flits, registered.
REQ-014 valid_o[NPORT]  output  1  outgoing valid, registered.
REQ-015 ready_i[NPORT]  input  1  downstream accept.
REQ-016 err_o  output  1  sticky protocol error flag.
REQ-017 pkt_cnt_o  output  16  completed merged packets, wraps at 2**16.

Function
REQ-018 Flit type encoding SHALL be HEAD=2'b00, BODY=2'b01, TAIL=2'b10, 2'b11 reserved (treated as BODY, sets err_o).
REQ-019 Each masked port SHALL have a FWFT FIFO; write on valid_i&ready_o; ready_o = ~full; unmasked ports: no FIFO, ready_o=0.
REQ-020 All = every masked FIFO non-empty; out_free = ~valid_q | ready_i[sel]; fire = All & out_free.
REQ-021 On fire, every masked FIFO SHALL pop exactly one flit in the same cycle; no partial pops ever.
REQ-022 FSM states: S_HEAD, S_BODY; reset state S_HEAD.
REQ-023 S_HEAD, fire, lowest-index masked flit HEAD: output = that flit unchanged; go S_BODY.
REQ-024 S_HEAD, fire, lowest-index flit not HEAD: flits dropped, no output, err_o set, stay S_HEAD.
REQ-025 S_BODY, fire: output type = lowest-index flit type; payload = reduction of all masked payloads; TAIL -> S_HEAD and pkt_cnt_o+1, else stay.
REQ-026 Any fire where masked flit types differ, or a HEAD seen in S_BODY, SHALL set err_o; reduction proceeds as above.
REQ-027 Sum: computed at DW-2+clog2(NPORT) bits; SAT=1 clamps to max/min signed DW-2 value; SAT=0 truncates.
REQ-028 Max: signed compare, largest payload wins.
REQ-029 Output register loads on fire; valid_q clears when ready_i[sel] & ~fire; holds data stable while valid_q & ~ready_i[sel].
REQ-030 data_o/valid_o on OUTPUT_SEL port = register; all other ports data_o=0, valid_o=0.
REQ-031 Latency: flit written cycle N -> visible on data_o cycle N+2 when unblocked; throughput 1 flit/cycle sustained.
REQ-032 Simultaneous FIFO write and pop on a full FIFO: ready_o=0 that cycle, write refused; empty FIFO write+read: no read (FWFT shows next cycle).
REQ-033 INPUT_MASK all zero: block SHALL never fire; valid_o stays 0.

Reset
REQ-034 rst=1 SHALL asynchronously empty all FIFOs, FSM->S_HEAD, valid_o=0, data_o=0, err_o=0, pkt_cnt_o=0.
REQ-035 Reset mid-packet SHALL discard partial packet; first post-reset flit must be HEAD.

Verification
REQ-036 MASK=ports1,2, SEL=0, MODE=0: HEAD, BODY 3 and 4, TAIL 5 and -7 -> out HEAD, BODY 7, TAIL -2, pkt_cnt_o=1.
REQ-037 SAT=1 sum 0x7FFFFFFF+1 -> 0x7FFFFFFF; SAT=0 -> 0x80000000.
REQ-038 MODE=1 payloads -5, 2, -1 -> 2.
REQ-039 ready_i[sel]=0 for 10 cycles, streaming inputs -> data_o stable, FIFOs fill, ready_o=0 at depth 4, no loss after release.
REQ-040 Port1 BODY while port2 HEAD in S_HEAD... lowest BODY -> dropped, err_o=1 sticky until rst.
REQ-041 rst asserted mid-BODY -> all outputs zero immediately, next HEAD merges normally.
